axi_mem_responder: RTL and testbench

AXI-MM responder (sink end) backed by on-chip dual-port RAM. It accepts the read and write bursts that the DMA copy engines issue as initiators and returns R/B responses. It is used as a local scratch or DDR stand-in, so the engines can be exercised without host or DDR memory. Read and write channels are fully independent, with one outstanding burst per direction.

---
 rtl/axi_mem_responder_if.sv | 54 +++++
 rtl/axi_mem_responder.sv | 185 ++++++++++++++++++
 tb/tb_axi_mem_responder.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_mem_responder_if.sv
// AXI-MM bus bundle between an initiator (master) and the RAM-backed responder (slave).
// Only full-width INCR bursts are carried, so there are no size or burst-type fields.
interface axi_mem_responder_if #(
  parameter int unsigned ADDR_WIDTH = 48,
  parameter int unsigned DATA_WIDTH = 512,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned LEN_WIDTH  = 8
);
  logic                    awvalid;
  logic                    awready;
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [LEN_WIDTH-1:0]    awlen;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [LEN_WIDTH-1:0]    arlen;
  logic                    rvalid;
  logic                    rready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;

  modport master (
    output awvalid, awid, awaddr, awlen,
    output wvalid, wdata, wstrb, wlast,
    output bready,
    output arvalid, arid, araddr, arlen,
    output rready,
    input  awready, wready, bvalid, bid, bresp,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  awvalid, awid, awaddr, awlen,
    input  wvalid, wdata, wstrb, wlast,
    input  bready,
    input  arvalid, arid, araddr, arlen,
    input  rready,
    output awready, wready, bvalid, bid, bresp,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/axi_mem_responder.sv
// AXI-MM responder backed by a dual-port RAM; independent read/write FSMs, one burst each.
// Optional AXI_MEM_RESPONDER_ERR_CHECK_EN: DECERR on out-of-range address, SLVERR on bad wlast.
module axi_mem_responder #(
    parameter int unsigned ADDR_WIDTH     = 48,
    parameter int unsigned DATA_WIDTH     = 512,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned LEN_WIDTH      = 8,
    parameter int unsigned MEM_DEPTH_LOG2 = 10
) (
    input  logic               clk,
    input  logic               reset,
    axi_mem_responder_if.slave s_axi
);
    localparam int unsigned OFFS       = $clog2(DATA_WIDTH / 8);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned DEPTH      = 1 << MEM_DEPTH_LOG2;
    localparam int unsigned WA_HI      = OFFS + MEM_DEPTH_LOG2;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} r_state_t;

    w_state_t                  r_wstate;
    w_state_t                  w_wnext;
    r_state_t                  r_rstate;
    r_state_t                  w_rnext;

    logic                      r_rdy_en;
    logic [ID_WIDTH-1:0]       r_wid;
    logic [ID_WIDTH-1:0]       r_rid;
    logic [MEM_DEPTH_LOG2-1:0] r_waddr;
    logic [MEM_DEPTH_LOG2-1:0] r_raddr;
    logic [LEN_WIDTH-1:0]      r_wlen;
    logic [LEN_WIDTH-1:0]      r_wcnt;
    logic [LEN_WIDTH-1:0]      r_rlen;
    logic [LEN_WIDTH-1:0]      r_rcnt;
    logic                      r_wdecerr;
    logic                      r_wslverr;
    logic                      r_rdecerr;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic [DATA_WIDTH-1:0]     r_mem [DEPTH];

    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_ar_hs;
    logic                      w_r_hs;
    logic                      w_wfinal;
    logic                      w_rfinal;
    logic                      w_aw_decerr;
    logic                      w_ar_decerr;
    logic                      w_unused;

`ifdef AXI_MEM_RESPONDER_ERR_CHECK_EN
    assign w_aw_decerr = |s_axi.awaddr[ADDR_WIDTH-1:WA_HI];
    assign w_ar_decerr = |s_axi.araddr[ADDR_WIDTH-1:WA_HI];
    assign w_unused    = ^{s_axi.awaddr[OFFS-1:0], s_axi.araddr[OFFS-1:0]};
`else
    assign w_aw_decerr = 1'b0;
    assign w_ar_decerr = 1'b0;
    assign w_unused    = ^{s_axi.awaddr[ADDR_WIDTH-1:WA_HI], s_axi.awaddr[OFFS-1:0],
                           s_axi.araddr[ADDR_WIDTH-1:WA_HI], s_axi.araddr[OFFS-1:0],
                           s_axi.wlast};
`endif

    assign w_wfinal = (r_wcnt == r_wlen);
    assign w_rfinal = (r_rcnt == r_rlen);

    assign w_aw_hs = s_axi.awvalid & s_axi.awready;
    assign w_w_hs  = s_axi.wvalid  & s_axi.wready;
    assign w_ar_hs = s_axi.arvalid & s_axi.arready;
    assign w_r_hs  = s_axi.rvalid  & s_axi.rready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wnext;
            r_rstate <= w_rnext;
        end
    end

    // Write FSM; ready is held off until the first edge after reset release
    always_comb begin
        w_wnext       = r_wstate;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.bvalid  = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                s_axi.awready = r_rdy_en;
                if (s_axi.awvalid && r_rdy_en) w_wnext = W_DATA;
            end
            W_DATA: begin
                s_axi.wready = 1'b1;
                if (s_axi.wvalid && w_wfinal) w_wnext = W_RESP;
            end
            W_RESP: begin
                s_axi.bvalid = 1'b1;
                if (s_axi.bready) w_wnext = W_IDLE;
            end
            default: w_wnext = W_IDLE;
        endcase
    end

    always_comb begin
        w_rnext       = r_rstate;
        s_axi.arready = 1'b0;
        s_axi.rvalid  = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                s_axi.arready = r_rdy_en;
                if (s_axi.arvalid && r_rdy_en) w_rnext = R_FETCH;
            end
            R_FETCH: w_rnext = R_SEND;
            R_SEND: begin
                s_axi.rvalid = 1'b1;
                if (s_axi.rready) w_rnext = w_rfinal ? R_IDLE : R_FETCH;
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    assign s_axi.bid   = r_wid;
    assign s_axi.bresp = r_wdecerr ? 2'b11 : (r_wslverr ? 2'b10 : 2'b00);
    assign s_axi.rid   = r_rid;
    assign s_axi.rdata = r_rdata;
    assign s_axi.rresp = r_rdecerr ? 2'b11 : 2'b00;
    assign s_axi.rlast = (r_rstate == R_SEND) && w_rfinal;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdy_en  <= 1'b0;
            r_wid     <= '0;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_wdecerr <= 1'b0;
            r_wslverr <= 1'b0;
            r_rid     <= '0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rcnt    <= '0;
            r_rdecerr <= 1'b0;
            r_rdata   <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_aw_hs) begin
                r_wid     <= s_axi.awid;
                r_waddr   <= s_axi.awaddr[WA_HI-1:OFFS];
                r_wlen    <= s_axi.awlen;
                r_wcnt    <= '0;
                r_wdecerr <= w_aw_decerr;
                r_wslverr <= 1'b0;
            end
            if (w_w_hs) begin
                r_waddr <= r_waddr + MEM_DEPTH_LOG2'(1);
                r_wcnt  <= r_wcnt + LEN_WIDTH'(1);
`ifdef AXI_MEM_RESPONDER_ERR_CHECK_EN
                if (s_axi.wlast != w_wfinal) r_wslverr <= 1'b1;
`endif
            end
            if (w_ar_hs) begin
                r_rid     <= s_axi.arid;
                r_raddr   <= s_axi.araddr[WA_HI-1:OFFS];
                r_rlen    <= s_axi.arlen;
                r_rcnt    <= '0;
                r_rdecerr <= w_ar_decerr;
            end
            // rdata is only loaded in R_FETCH, so it holds while R_SEND waits on rready
            if (r_rstate == R_FETCH) r_rdata <= r_rdecerr ? '0 : r_mem[r_raddr];
            if (w_r_hs && !w_rfinal) begin
                r_raddr <= r_raddr + MEM_DEPTH_LOG2'(1);
                r_rcnt  <= r_rcnt + LEN_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_w_hs && !r_wdecerr) begin
            for (int unsigned b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi.wstrb[b]) r_mem[r_waddr][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
            end
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder (64-bit data, 16-word RAM so address wrap is reachable).
module tb_axi_mem_responder;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  axi_mem_responder_if #(.ADDR_WIDTH(48), .DATA_WIDTH(64), .ID_WIDTH(8), .LEN_WIDTH(8)) bus ();

  axi_mem_responder #(
    .ADDR_WIDTH(48), .DATA_WIDTH(64), .ID_WIDTH(8), .LEN_WIDTH(8), .MEM_DEPTH_LOG2(4)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .s_axi(bus)
  );

  logic [63:0] d_pat [4] = '{64'h0123456789ABCDEF, 64'hFEDCBA9876543210,
                             64'hA5A5A5A55A5A5A5A, 64'h0F0F0F0FF0F0F0F0};
  logic [63:0] e_pat [4] = '{64'hE0E0E0E011111111, 64'hE1E1E1E122222222,
                             64'hE2E2E2E233333333, 64'hE3E3E3E344444444};
  logic [63:0] wd [16];
  logic [7:0]  ws [16];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_aw_w(input logic [7:0] id, input logic [47:0] addr, input int len, input int lastbeat);
    int n;
    bus.awvalid = 1'b1; bus.awid = id; bus.awaddr = addr; bus.awlen = 8'(len);
    n = 0;
    while (bus.awready !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (bus.awready !== 1'b1) begin errors++; $display("FAIL aw_timeout: awready=%b required 1", bus.awready); end
    step();
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.wvalid = 1'b1; bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == lastbeat);
      n = 0;
      while (bus.wready !== 1'b1 && n < 50) begin step(); n++; end
      checks++;
      if (bus.wready !== 1'b1) begin errors++; $display("FAIL w_timeout beat %0d: wready=%b required 1", i, bus.wready); end
      step();
    end
    bus.wvalid = 1'b0; bus.wlast = 1'b0;
  endtask

  task automatic do_b(output logic [7:0] id, output logic [1:0] resp);
    int n;
    bus.bready = 1'b1;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (bus.bvalid !== 1'b1) begin errors++; $display("FAIL b_timeout: bvalid=%b required 1", bus.bvalid); end
    id = bus.bid; resp = bus.bresp;
    step();
    bus.bready = 1'b0;
  endtask

  task automatic do_ar(input logic [7:0] id, input logic [47:0] addr, input int len, output int lat);
    int n;
    bus.arvalid = 1'b1; bus.arid = id; bus.araddr = addr; bus.arlen = 8'(len);
    n = 0;
    while (bus.arready !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (bus.arready !== 1'b1) begin errors++; $display("FAIL ar_timeout: arready=%b required 1", bus.arready); end
    step();
    bus.arvalid = 1'b0;
    lat = 1;
    while (bus.rvalid !== 1'b1 && lat < 50) begin step(); lat++; end
  endtask

  task automatic do_rbeat(output logic [63:0] data, output logic [7:0] id, output logic [1:0] resp, output logic last);
    int n;
    bus.rready = 1'b1;
    n = 0;
    while (bus.rvalid !== 1'b1 && n < 50) begin step(); n++; end
    checks++;
    if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL r_timeout: rvalid=%b required 1", bus.rvalid); end
    data = bus.rdata; id = bus.rid; resp = bus.rresp; last = bus.rlast;
    step();
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL rst_awready: got %b want 0", bus.awready); end
    checks++; if (bus.arready !== 1'b0) begin errors++; $display("FAIL rst_arready: got %b want 0", bus.arready); end
    checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL rst_wready: got %b want 0", bus.wready); end
    checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid: got %b want 0", bus.bvalid); end
    checks++; if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0) begin errors++; $display("FAIL rst_rvalid_rlast: got %b%b want 00", bus.rvalid, bus.rlast); end
    checks++; if (bus.rdata !== 64'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.rdata); end
    reset = 1'b0;
    #1;
    checks++; if (bus.awready !== 1'b0) begin errors++; $display("FAIL rel_awready_early: got %b want 0", bus.awready); end
    step();
    checks++; if (bus.awready !== 1'b1 || bus.arready !== 1'b1) begin errors++; $display("FAIL rel_ready: got aw=%b ar=%b want 11", bus.awready, bus.arready); end
  endtask

  task automatic test_burst();
    logic [7:0] id; logic [1:0] resp; logic [63:0] rd; logic last; int lat;
    for (int i = 0; i < 4; i++) begin wd[i] = d_pat[i]; ws[i] = 8'hFF; end
    do_aw_w(8'h5A, 48'h40, 3, 3);
    do_b(id, resp);
    checks++; if (id !== 8'h5A) begin errors++; $display("FAIL burst_bid: got %h want 5a", id); end
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL burst_bresp: got %b want 00", resp); end
    do_ar(8'h11, 48'h40, 3, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL burst_latency: got %0d want 2", lat); end
    for (int i = 0; i < 4; i++) begin
      do_rbeat(rd, id, resp, last);
      checks++; if (rd !== d_pat[i]) begin errors++; $display("FAIL burst_rdata[%0d]: got %h want %h", i, rd, d_pat[i]); end
      checks++; if (id !== 8'h11 || resp !== 2'b00) begin errors++; $display("FAIL burst_rid_rresp[%0d]: got %h/%b want 11/00", i, id, resp); end
      checks++; if (last !== (i == 3)) begin errors++; $display("FAIL burst_rlast[%0d]: got %b want %b", i, last, (i == 3)); end
    end
  endtask

  task automatic test_strobe();
    logic [7:0] id; logic [1:0] resp; logic [63:0] rd; logic last; int lat;
    wd[0] = 64'hFFFFFFFFFFFFFFFF; ws[0] = 8'hFF;
    do_aw_w(8'h01, 48'h0, 0, 0);
    do_b(id, resp);
    wd[0] = 64'h00000000000000AB; ws[0] = 8'h01;
    do_aw_w(8'h02, 48'h0, 0, 0);
    do_b(id, resp);
    checks++; if (id !== 8'h02 || resp !== 2'b00) begin errors++; $display("FAIL strobe_b: got %h/%b want 02/00", id, resp); end
    do_ar(8'h03, 48'h0, 0, lat);
    do_rbeat(rd, id, resp, last);
    checks++; if (rd !== 64'hFFFFFFFFFFFFFFAB) begin errors++; $display("FAIL strobe_rdata: got %h want ffffffffffffffab", rd); end
    checks++; if (last !== 1'b1) begin errors++; $display("FAIL strobe_rlast: got %b want 1", last); end
  endtask

  task automatic test_wrap();
    logic [7:0] id; logic [1:0] resp; logic [63:0] rd; logic last; int lat;
    for (int i = 0; i < 4; i++) begin wd[i] = e_pat[i]; ws[i] = 8'hFF; end
    do_aw_w(8'h04, 48'h70, 3, 3);
    do_b(id, resp);
    do_ar(8'h05, 48'h0, 0, lat);
    do_rbeat(rd, id, resp, last);
    checks++; if (rd !== e_pat[2]) begin errors++; $display("FAIL wrap_word0: got %h want %h", rd, e_pat[2]); end
    do_ar(8'h06, 48'h8, 0, lat);
    do_rbeat(rd, id, resp, last);
    checks++; if (rd !== e_pat[3]) begin errors++; $display("FAIL wrap_word1: got %h want %h", rd, e_pat[3]); end
    do_ar(8'h07, 48'h70, 3, lat);
    for (int i = 0; i < 4; i++) begin
      do_rbeat(rd, id, resp, last);
      checks++; if (rd !== e_pat[i]) begin errors++; $display("FAIL wrap_burst[%0d]: got %h want %h", i, rd, e_pat[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] id; logic [1:0] resp; logic [63:0] rd; logic last; int lat; int n;
    wd[0] = 64'h3333333333333333; wd[1] = 64'h4444444444444444; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_aw_w(8'h33, 48'h20, 1, 1);
    bus.bready = 1'b0;
    n = 0;
    while (bus.bvalid !== 1'b1 && n < 50) begin step(); n++; end
    for (int c = 0; c < 5; c++) begin
      checks++; if (bus.bvalid !== 1'b1 || bus.awready !== 1'b0) begin errors++; $display("FAIL bstall[%0d]: got bvalid=%b awready=%b want 1 0", c, bus.bvalid, bus.awready); end
      step();
    end
    do_b(id, resp);
    checks++; if (id !== 8'h33 || resp !== 2'b00) begin errors++; $display("FAIL bstall_b: got %h/%b want 33/00", id, resp); end
    checks++; if (bus.awready !== 1'b1) begin errors++; $display("FAIL bstall_awready_after: got %b want 1", bus.awready); end
    do_ar(8'h22, 48'h40, 3, lat);
    do_rbeat(rd, id, resp, last);
    checks++; if (rd !== d_pat[0]) begin errors++; $display("FAIL rstall_beat0: got %h want %h", rd, d_pat[0]); end
    n = 0;
    while (bus.rvalid !== 1'b1 && n < 50) begin step(); n++; end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== d_pat[1] || bus.rlast !== 1'b0 || bus.rid !== 8'h22) begin
        errors++; $display("FAIL rstall[%0d]: got v=%b d=%h l=%b id=%h want 1 %h 0 22", c, bus.rvalid, bus.rdata, bus.rlast, bus.rid, d_pat[1]);
      end
      step();
    end
    for (int i = 1; i < 4; i++) begin
      do_rbeat(rd, id, resp, last);
      checks++; if (rd !== d_pat[i] || last !== (i == 3)) begin errors++; $display("FAIL rstall_rest[%0d]: got %h/%b want %h/%b", i, rd, last, d_pat[i], (i == 3)); end
    end
  endtask

  task automatic test_reset_midburst();
    logic [7:0] id; logic [1:0] resp; logic [63:0] rd; logic last; int lat; int n;
    do_ar(8'h44, 48'h40, 3, lat);
    do_rbeat(rd, id, resp, last);
    n = 0;
    while (bus.rvalid !== 1'b1 && n < 50) begin step(); n++; end
    reset = 1'b1;
    #1;
    checks++; if (bus.rvalid !== 1'b0 || bus.rlast !== 1'b0) begin errors++; $display("FAIL midrst_rvalid: got %b%b want 00", bus.rvalid, bus.rlast); end
    checks++; if (bus.rdata !== 64'h0) begin errors++; $display("FAIL midrst_rdata: got %h want 0", bus.rdata); end
    step(); step();
    reset = 1'b0;
    #1;
    checks++; if (bus.arready !== 1'b0) begin errors++; $display("FAIL midrst_arready_early: got %b want 0", bus.arready); end
    step();
    checks++; if (bus.arready !== 1'b1) begin errors++; $display("FAIL midrst_arready: got %b want 1", bus.arready); end
    do_ar(8'h45, 48'h40, 3, lat);
    for (int i = 0; i < 4; i++) begin
      do_rbeat(rd, id, resp, last);
      checks++; if (rd !== d_pat[i] || id !== 8'h45) begin errors++; $display("FAIL midrst_reread[%0d]: got %h/%h want %h/45", i, rd, id, d_pat[i]); end
    end
  endtask

`ifdef AXI_MEM_RESPONDER_ERR_CHECK_EN
  task automatic test_err_check();
    logic [7:0] id; logic [1:0] resp; logic [63:0] rd; logic last; int lat;
    for (int i = 0; i < 4; i++) begin wd[i] = ~d_pat[i]; ws[i] = 8'hFF; end
    do_aw_w(8'h60, 48'h40, 3, 1);
    do_b(id, resp);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL err_early_wlast: got %b want 10", resp); end
    do_aw_w(8'h61, 48'h40, 0, 5);
    do_b(id, resp);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL err_missing_wlast: got %b want 10", resp); end
    do_ar(8'h62, 48'h40, 3, lat);
    for (int i = 0; i < 4; i++) begin
      do_rbeat(rd, id, resp, last);
      checks++; if (rd !== ~d_pat[i]) begin errors++; $display("FAIL err_slverr_written[%0d]: got %h want %h", i, rd, ~d_pat[i]); end
    end
    wd[0] = 64'h1234123412341234;
    do_aw_w(8'h63, 48'h0100_0000_0040, 0, 0);
    do_b(id, resp);
    checks++; if (resp !== 2'b11 || id !== 8'h63) begin errors++; $display("FAIL err_decerr_b: got %b/%h want 11/63", resp, id); end
    do_ar(8'h64, 48'h40, 0, lat);
    do_rbeat(rd, id, resp, last);
    checks++; if (rd !== ~d_pat[0]) begin errors++; $display("FAIL err_decerr_unchanged: got %h want %h", rd, ~d_pat[0]); end
    do_ar(8'h65, 48'h0100_0000_0040, 1, lat);
    for (int i = 0; i < 2; i++) begin
      do_rbeat(rd, id, resp, last);
      checks++; if (rd !== 64'h0 || resp !== 2'b11 || last !== (i == 1)) begin errors++; $display("FAIL err_decerr_read[%0d]: got %h/%b/%b want 0/11/%b", i, rd, resp, last, (i == 1)); end
    end
  endtask
`else
  task automatic test_alias();
    logic [7:0] id; logic [1:0] resp; logic [63:0] rd; logic last; int lat;
    wd[0] = 64'hCAFEF00DCAFEF00D; ws[0] = 8'hFF;
    do_aw_w(8'h70, 48'h0100_0000_0000, 0, 0);
    do_b(id, resp);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL alias_bresp: got %b want 00", resp); end
    do_ar(8'h71, 48'h0, 0, lat);
    do_rbeat(rd, id, resp, last);
    checks++; if (rd !== 64'hCAFEF00DCAFEF00D || resp !== 2'b00) begin errors++; $display("FAIL alias_rdata: got %h/%b want cafef00dcafef00d/00", rd, resp); end
    wd[0] = 64'h5555555555555555; wd[1] = 64'h6666666666666666; ws[0] = 8'hFF; ws[1] = 8'hFF;
    do_aw_w(8'h72, 48'h30, 1, 0);
    do_b(id, resp);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL wlast_ignored_bresp: got %b want 00", resp); end
    do_ar(8'h73, 48'h38, 0, lat);
    do_rbeat(rd, id, resp, last);
    checks++; if (rd !== 64'h6666666666666666) begin errors++; $display("FAIL wlast_ignored_beat1: got %h want 6666666666666666", rd); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    bus.awvalid = 1'b0; bus.awid = '0; bus.awaddr = '0; bus.awlen = '0;
    bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.bready = 1'b0;
    bus.arvalid = 1'b0; bus.arid = '0; bus.araddr = '0; bus.arlen = '0;
    bus.rready = 1'b0;
    test_reset();
    test_burst();
    test_strobe();
    test_wrap();
    test_backpressure();
    test_reset_midburst();
`ifdef AXI_MEM_RESPONDER_ERR_CHECK_EN
    test_err_check();
`else
    test_alias();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
